// File: rtl/syscon_pin_rx_pkg.sv
// Shared definitions for the syscon pin receiver: FSM state encoding and
// default parameter values used by the top level.
package syscon_pin_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_LOCK_COUNT  = 4;
    localparam int DEF_TOL         = 1;
    localparam int DEF_RST_HOLD    = 3;

endpackage

// File: rtl/syscon_pin_rx_sync.sv
// N-stage flip-flop synchronizer for one asynchronous pin. RST_VAL selects
// the level every stage takes during reset, so a reset-pin chain can come
// up asserted while a clock-pin chain comes up low.
module syscon_pin_rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain_reg;

    // Shift the pin through the chain; the oldest stage is the synchronized copy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chain_reg <= {STAGES{RST_VAL}};
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], din};
        end
    end

    assign dout = chain_reg[STAGES-1];

endmodule

// File: rtl/syscon_pin_rx.sv
// Receive side of the syscon pin pair. Synchronizes clk_pin / rst_pin,
// debounces the reset pin, emits a tick per clk_pin rise and measures the
// clk_pin half-period, declaring lock once successive half-periods agree.
module syscon_pin_rx
    import syscon_pin_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int TOL         = DEF_TOL,
    parameter int RST_HOLD    = DEF_RST_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_pin,
    input  logic             rst_pin,
    output logic             ext_rst,
    output logic             ext_tick,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             err
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int RCNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_NEAR  = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W:0]    TOL_W     = (CNT_W+1)'(TOL);
    localparam logic [GOOD_W-1:0] LOCK_VAL  = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_HOLD - 1);

    logic              s_clk;
    logic              s_rst;
    logic              p_clk_reg;
    logic              clk_edge;
    logic [CNT_W-1:0]  hp_cnt_reg;
    logic [CNT_W-1:0]  prev_reg;
    logic [GOOD_W-1:0] good_reg;
    logic [GOOD_W-1:0] good_next;
    logic [RCNT_W-1:0] rcnt_reg;
    state_t            state_reg;

    logic [CNT_W:0]    meas_wide;
    logic [CNT_W-1:0]  meas;
    logic [CNT_W:0]    diff;
    logic              in_tol;
    logic              stopped;
    logic              overflow;

    syscon_pin_rx_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_clk (
        .clk  (clk),
        .rst  (rst),
        .din  (clk_pin),
        .dout (s_clk)
    );

    syscon_pin_rx_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_rst (
        .clk  (clk),
        .rst  (rst),
        .din  (rst_pin),
        .dout (s_rst)
    );

    // Edge detect plus measurement arithmetic; the difference is taken one
    // bit wider than the counter so the unsigned subtraction never wraps.
    always_comb begin
        clk_edge  = s_clk ^ p_clk_reg;
        meas_wide = {1'b0, hp_cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
        meas      = meas_wide[CNT_W] ? CNT_MAX : meas_wide[CNT_W-1:0];
        diff      = (meas >= prev_reg) ? ({1'b0, meas} - {1'b0, prev_reg})
                                       : ({1'b0, prev_reg} - {1'b0, meas});
        in_tol    = (diff <= TOL_W);
        stopped   = ({1'b0, hp_cnt_reg} > ({1'b0, prev_reg} + TOL_W));
        overflow  = (hp_cnt_reg == CNT_NEAR);
        if (good_reg == '0) begin
            good_next = GOOD_ONE;
        end else if (in_tol) begin
            good_next = good_reg + 1'b1;
        end else begin
            good_next = GOOD_ONE;
        end
    end

    // Previous-sample flop and registered rising-edge tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p_clk_reg <= 1'b0;
            ext_tick  <= 1'b0;
        end else begin
            p_clk_reg <= s_clk;
            ext_tick  <= s_clk & ~p_clk_reg;
        end
    end

    // Half-period counter: clears on every edge, otherwise saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hp_cnt_reg <= '0;
        end else if (clk_edge) begin
            hp_cnt_reg <= '0;
        end else if (hp_cnt_reg != CNT_MAX) begin
            hp_cnt_reg <= hp_cnt_reg + 1'b1;
        end
    end

    // Reset-pin debounce: ext_rst follows s_rst only after RST_HOLD differing samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_rst  <= 1'b1;
            rcnt_reg <= '0;
        end else if (s_rst == ext_rst) begin
            rcnt_reg <= '0;
        end else if (rcnt_reg == RCNT_LAST) begin
            ext_rst  <= s_rst;
            rcnt_reg <= '0;
        end else begin
            rcnt_reg <= rcnt_reg + 1'b1;
        end
    end

    // Lock FSM: measure half-periods, lock on agreement, flag loss of lock or overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            good_reg    <= '0;
            prev_reg    <= '0;
            half_period <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clk_edge) begin
                        state_reg <= MEASURE;
                        good_reg  <= '0;
                    end else if (overflow) begin
                        err <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (clk_edge) begin
                        half_period <= meas;
                        prev_reg    <= meas;
                        good_reg    <= good_next;
                        if (good_next == LOCK_VAL) begin
                            state_reg <= LOCKED;
                            locked    <= 1'b1;
                        end
                    end else if (overflow) begin
                        err       <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                LOCKED: begin
                    if (clk_edge) begin
                        half_period <= meas;
                        prev_reg    <= meas;
                        if (!in_tol) begin
                            err       <= 1'b1;
                            locked    <= 1'b0;
                            good_reg  <= GOOD_ONE;
                            state_reg <= MEASURE;
                        end
                    end else if (overflow || stopped) begin
                        // Saturation and a stopped clock share one pulse and both fall back to IDLE.
                        err       <= 1'b1;
                        locked    <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule
